// File: rtl/lights_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lights_pkg
// Brief    : Phase/state encoding, light-bus code constants and phase helpers
//            shared by the traffic-light bus monitor.
// Revision : 1.0
// ============================================================================
package lights_pkg;

    // Phase states share their 2-bit phase encoding in bits [1:0].
    typedef enum logic [2:0] {
        ST_RED       = 3'd0,
        ST_RED_AMBER = 3'd1,
        ST_GREEN     = 3'd2,
        ST_AMBER     = 3'd3,
        ST_SYNC      = 3'd4
    } state_t;

    localparam logic [2:0] CODE_RED       = 3'b100;
    localparam logic [2:0] CODE_RED_AMBER = 3'b110;
    localparam logic [2:0] CODE_GREEN     = 3'b001;
    localparam logic [2:0] CODE_AMBER     = 3'b010;

    function automatic state_t next_phase(input state_t s);
        case (s)
            ST_RED:       return ST_RED_AMBER;
            ST_RED_AMBER: return ST_GREEN;
            ST_GREEN:     return ST_AMBER;
            ST_AMBER:     return ST_RED;
            default:      return ST_SYNC;
        endcase
    endfunction

    // Illegal codes map to ST_SYNC.
    function automatic state_t decode_code(input logic [2:0] code);
        case (code)
            CODE_RED:       return ST_RED;
            CODE_RED_AMBER: return ST_RED_AMBER;
            CODE_GREEN:     return ST_GREEN;
            CODE_AMBER:     return ST_AMBER;
            default:        return ST_SYNC;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lights_dwell_ctr.sv
`default_nettype none
// ============================================================================
// Module   : lights_dwell_ctr
// Brief    : Saturating phase dwell counter with load-1 / increment / clear
//            controls and at-max / below-min flags.
// Revision : 1.0
// ============================================================================
module lights_dwell_ctr #(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_load,
    input  logic i_inc,
    output logic o_at_max,
    output logic o_below_min
);

    localparam int c_dw_w = $clog2(MAX_DWELL + 1);
    localparam logic [c_dw_w-1:0] c_max = c_dw_w'(MAX_DWELL);
    localparam logic [c_dw_w-1:0] c_min = c_dw_w'(MIN_DWELL);

    logic [c_dw_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_dw_w'(1);
        end else if (i_inc && (r_cnt != c_max)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_max    = (r_cnt == c_max);
    assign o_below_min = (r_cnt < c_min);

endmodule
`default_nettype wire

// File: rtl/lights_monitor.sv
`default_nettype none
// ============================================================================
// Module   : lights_monitor
// Brief    : Passive checker for the {red, amber, green} bus: phase order,
//            dwell limits, sticky error flags and cycle/error statistics.
//            Statistics counters exist only with LIGHTS_MON_STATS_EN defined.
// Revision : 1.0
// ============================================================================
module lights_monitor
    import lights_pkg::*;
#(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             red,
    input  logic             amber,
    input  logic             green,
    input  logic             clr,
    output logic             locked,
    output logic [1:0]       phase,
    output logic             err_illegal,
    output logic             err_seq,
    output logic             err_dwell,
    output logic             err_pulse,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] err_count
);

    state_t     r_state, w_state_nxt, w_code_st;
    logic [2:0] w_code;
    logic       w_legal;
    logic       w_dw_load, w_dw_inc, w_dw_clr, w_at_max, w_below_min;
    logic       w_set_ill, w_set_seq, w_set_dwell, w_cycle_done, w_err_event;
    logic       r_locked, r_err_illegal, r_err_seq, r_err_dwell, r_err_pulse;
    logic [1:0] r_phase;

    assign w_code    = {red, amber, green};
    assign w_code_st = decode_code(w_code);
    assign w_legal   = (w_code_st != ST_SYNC);

    lights_dwell_ctr #(
        .MIN_DWELL (MIN_DWELL),
        .MAX_DWELL (MAX_DWELL)
    ) u_dwell (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_dw_clr),
        .i_load      (w_dw_load),
        .i_inc       (w_dw_inc),
        .o_at_max    (w_at_max),
        .o_below_min (w_below_min)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_dw_load    = 1'b0;
        w_dw_inc     = 1'b0;
        w_dw_clr     = 1'b0;
        w_set_ill    = 1'b0;
        w_set_seq    = 1'b0;
        w_set_dwell  = 1'b0;
        w_cycle_done = 1'b0;
        if (r_state == ST_SYNC) begin
            if (w_legal) begin
                w_state_nxt = w_code_st;
                w_dw_load   = 1'b1;
            end else begin
                w_set_ill = 1'b1;
            end
        end else if (!w_legal) begin
            w_set_ill   = 1'b1;
            w_state_nxt = ST_SYNC;
            w_dw_clr    = 1'b1;
        end else if (w_code_st == r_state) begin
            w_dw_inc    = 1'b1;
            w_set_dwell = w_at_max;
        end else if (w_code_st == next_phase(r_state)) begin
            w_state_nxt  = w_code_st;
            w_dw_load    = 1'b1;
            w_set_dwell  = w_below_min;
            w_cycle_done = (r_state == ST_AMBER);
        end else begin
            // Legal but out of order: flag it and follow the observed phase.
            w_set_seq   = 1'b1;
            w_state_nxt = w_code_st;
            w_dw_load   = 1'b1;
        end
    end

    assign w_err_event = w_set_ill | w_set_seq | w_set_dwell;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_SYNC;
            r_locked      <= 1'b0;
            r_phase       <= 2'd0;
            r_err_illegal <= 1'b0;
            r_err_seq     <= 1'b0;
            r_err_dwell   <= 1'b0;
            r_err_pulse   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_locked      <= (w_state_nxt != ST_SYNC);
            r_phase       <= w_state_nxt[1:0];
            // A fresh error outranks a simultaneous clear.
            r_err_illegal <= w_set_ill   | (r_err_illegal & ~clr);
            r_err_seq     <= w_set_seq   | (r_err_seq     & ~clr);
            r_err_dwell   <= w_set_dwell | (r_err_dwell   & ~clr);
            r_err_pulse   <= w_err_event;
        end
    end

    assign locked      = r_locked;
    assign phase       = r_phase;
    assign err_illegal = r_err_illegal;
    assign err_seq     = r_err_seq;
    assign err_dwell   = r_err_dwell;
    assign err_pulse   = r_err_pulse;

`ifdef LIGHTS_MON_STATS_EN
    logic [CNT_W-1:0] r_cycle_count, r_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_count <= '0;
            r_err_count   <= '0;
        end else begin
            if (w_cycle_done) begin
                r_cycle_count <= r_cycle_count + 1'b1;
            end
            if (w_err_event && !(&r_err_count)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign cycle_count = r_cycle_count;
    assign err_count   = r_err_count;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_cycle_done;
    assign cycle_count    = '0;
    assign err_count      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lights_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_lights_monitor
// Brief    : Scoreboard bench for lights_monitor (default and MIN=3/MAX=5).
// Revision : 1.0
// ============================================================================
module tb_lights_monitor;

`ifdef LIGHTS_MON_STATS_EN
    localparam bit c_stats = 1'b1;
`else
    localparam bit c_stats = 1'b0;
`endif

    typedef struct packed {
        logic       locked;
        logic [1:0] phase;
        logic       ill;
        logic       seq;
        logic       dw;
        logic       pulse;
        logic [7:0] cyc;
        logic [7:0] errc;
    } exp_t;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       rst2_n = 1'b1;
    logic [2:0] code0  = 3'b000;
    logic [2:0] code1  = 3'b000;
    logic       clr0   = 1'b0;
    logic       clr1   = 1'b0;

    logic       locked0, ill0, seq0, dw0, pulse0;
    logic [1:0] phase0;
    logic [7:0] cyc0, errc0;
    logic       locked1, ill1, seq1, dw1, pulse1;
    logic [1:0] phase1;
    logic [7:0] cyc1, errc1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_errs   = 0;

    always #5 clk = ~clk;

    lights_monitor dut (
        .clk(clk), .rst_n(rst_n),
        .red(code0[2]), .amber(code0[1]), .green(code0[0]), .clr(clr0),
        .locked(locked0), .phase(phase0),
        .err_illegal(ill0), .err_seq(seq0), .err_dwell(dw0), .err_pulse(pulse0),
        .cycle_count(cyc0), .err_count(errc0)
    );

    lights_monitor #(.MIN_DWELL(3), .MAX_DWELL(5), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst2_n),
        .red(code1[2]), .amber(code1[1]), .green(code1[0]), .clr(clr1),
        .locked(locked1), .phase(phase1),
        .err_illegal(ill1), .err_seq(seq1), .err_dwell(dw1), .err_pulse(pulse1),
        .cycle_count(cyc1), .err_count(errc1)
    );

    function automatic exp_t mk(input bit l, input int p, input bit i, input bit s,
                                input bit d, input bit pu, input int cy, input int ec);
        exp_t e;
        e.locked = l;
        e.phase  = 2'(p);
        e.ill    = i;
        e.seq    = s;
        e.dw     = d;
        e.pulse  = pu;
        e.cyc    = c_stats ? 8'(cy) : 8'd0;
        e.errc   = c_stats ? 8'(ec) : 8'd0;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input logic l, input logic [1:0] p,
                       input logic i, input logic s, input logic d, input logic pu,
                       input logic [7:0] cy, input logic [7:0] ec, input exp_t e);
        chk({tag, ".locked"}, int'(l), int'(e.locked));
        if (e.locked) chk({tag, ".phase"}, int'(p), int'(e.phase));
        chk({tag, ".err_illegal"}, int'(i), int'(e.ill));
        chk({tag, ".err_seq"}, int'(s), int'(e.seq));
        chk({tag, ".err_dwell"}, int'(d), int'(e.dw));
        chk({tag, ".err_pulse"}, int'(pu), int'(e.pulse));
        chk({tag, ".cycle_count"}, int'(cy), int'(e.cyc));
        chk({tag, ".err_count"}, int'(ec), int'(e.errc));
    endtask

    // Monitor: one registered response per sample, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                cmp("dut", locked0, phase0, ill0, seq0, dw0, pulse0, cyc0, errc0, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp("dut2", locked1, phase1, ill1, seq1, dw1, pulse1, cyc1, errc1, e);
            end
        end
    end

    task automatic step0(input logic [2:0] c, input logic cl, input exp_t e);
        code0 = c;
        clr0  = cl;
        q0.push_back(e);
        @(negedge clk);
    endtask

    task automatic step1(input logic [2:0] c, input logic cl, input exp_t e);
        code1 = c;
        clr1  = cl;
        q1.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #1;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        #2;
        cmp("reset", locked0, phase0, ill0, seq0, dw0, pulse0, cyc0, errc0,
            mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        // Two full legal cycles plus the second AMBER->RED
        step0(3'b100, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
        step0(3'b110, 0, mk(1, 1, 0, 0, 0, 0, 0, 0));
        step0(3'b001, 0, mk(1, 2, 0, 0, 0, 0, 0, 0));
        step0(3'b010, 0, mk(1, 3, 0, 0, 0, 0, 0, 0));
        step0(3'b100, 0, mk(1, 0, 0, 0, 0, 0, 1, 0));
        step0(3'b110, 0, mk(1, 1, 0, 0, 0, 0, 1, 0));
        step0(3'b001, 0, mk(1, 2, 0, 0, 0, 0, 1, 0));
        step0(3'b010, 0, mk(1, 3, 0, 0, 0, 0, 1, 0));
        step0(3'b100, 0, mk(1, 0, 0, 0, 0, 0, 2, 0));
        step0(3'b110, 0, mk(1, 1, 0, 0, 0, 0, 2, 0));
        step0(3'b001, 0, mk(1, 2, 0, 0, 0, 0, 2, 0));
        // Illegal code while in GREEN, then resync on RED
        step0(3'b101, 0, mk(0, 0, 1, 0, 0, 1, 2, 1));
        step0(3'b100, 0, mk(1, 0, 1, 0, 0, 0, 2, 1));
        // Clear with a clean sample
        step0(3'b110, 1, mk(1, 1, 0, 0, 0, 0, 2, 1));
        step0(3'b001, 0, mk(1, 2, 0, 0, 0, 0, 2, 1));
        step0(3'b010, 0, mk(1, 3, 0, 0, 0, 0, 2, 1));
        step0(3'b100, 0, mk(1, 0, 0, 0, 0, 0, 3, 1));
        // RED -> GREEN out of order
        step0(3'b001, 0, mk(1, 2, 0, 1, 0, 1, 3, 2));
        // GREEN held a second cycle with MAX_DWELL=1
        step0(3'b001, 0, mk(1, 2, 0, 1, 1, 1, 3, 3));
        // Clear together with an illegal code
        step0(3'b111, 1, mk(0, 0, 1, 0, 0, 1, 3, 4));
        step0(3'b100, 1, mk(1, 0, 0, 0, 0, 0, 3, 4));
        step0(3'b110, 0, mk(1, 1, 0, 0, 0, 0, 3, 4));

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async_rst", locked0, phase0, ill0, seq0, dw0, pulse0, cyc0, errc0,
            mk(0, 0, 0, 0, 0, 0, 0, 0));
        code0 = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        step0(3'b000, 0, mk(0, 0, 1, 0, 0, 1, 0, 1));
        step0(3'b010, 0, mk(1, 3, 1, 0, 0, 0, 0, 1));
        step0(3'b100, 0, mk(1, 0, 1, 0, 0, 0, 1, 1));

        // MIN_DWELL=3, MAX_DWELL=5 instance
        rst2_n = 1'b1;
        step1(3'b100, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
        step1(3'b100, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
        step1(3'b100, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
        step1(3'b110, 0, mk(1, 1, 0, 0, 0, 0, 0, 0));
        step1(3'b110, 0, mk(1, 1, 0, 0, 0, 0, 0, 0));
        step1(3'b001, 0, mk(1, 2, 0, 0, 1, 1, 0, 1));
        step1(3'b001, 1, mk(1, 2, 0, 0, 0, 0, 0, 1));
        step1(3'b001, 0, mk(1, 2, 0, 0, 0, 0, 0, 1));
        step1(3'b010, 0, mk(1, 3, 0, 0, 0, 0, 0, 1));
        for (int k = 0; k < 4; k++) begin
            step1(3'b010, 0, mk(1, 3, 0, 0, 0, 0, 0, 1));
        end
        step1(3'b010, 0, mk(1, 3, 0, 0, 1, 1, 0, 2));
        step1(3'b010, 0, mk(1, 3, 0, 0, 1, 1, 0, 3));
        step1(3'b100, 0, mk(1, 0, 0, 0, 1, 0, 1, 3));

        repeat (3) @(negedge clk);
        chk("scoreboard_drain", q0.size() + q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
